image_frame_receiver: RTL
=========================

IMAGE_FRAME_RECEIVER -- requirements
Module: image_frame_receiver

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 320, meaning pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 240, meaning lines per frame.
REQ-003 SHALL have parameter PIX_W, default 12, meaning RGB444 pixel width.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_reset  input  1  sender frame-restart strobe, level-high.
REQ-007 SHALL have port pixel_valid  input  1  pixel_in valid this cycle.
REQ-008 SHALL have port pixel_in  input  PIX_W  incoming pixel.
REQ-009 SHALL have port wr_en  output  1  frame buffer write strobe.
REQ-010 SHALL have port wr_addr  output  ADDR_W = $clog2(IMG_WIDTH*IMG_HEIGHT)  linear buffer address.
REQ-011 SHALL have port wr_data  output  PIX_W  pixel to write.
REQ-012 SHALL have port image_ready  output  1  one-cycle pulse: frame complete, sender may proceed.
REQ-013 SHALL have port busy  output  1  high in SYNC or CAPTURE.

Function
REQ-014 SHALL implement FSM states IDLE, SYNC, CAPTURE, DONE.
REQ-015 IDLE -> SYNC when frame_reset=1; pixel_valid ignored in IDLE.
REQ-016 SYNC: hold address counter at 0; -> CAPTURE on first cycle frame_reset=0; pixel_valid ignored.
REQ-017 CAPTURE: each cycle pixel_valid=1 SHALL register wr_en=1, wr_data=pixel_in, wr_addr=current count one cycle later; count then increments by 1.
REQ-018 Address SHALL equal y*IMG_WIDTH+x; x wraps IMG_WIDTH-1 -> 0 incrementing y.
REQ-019 Accepting pixel at address IMG_WIDTH*IMG_HEIGHT-1 SHALL move to DONE; no address beyond this is ever emitted.
REQ-020 DONE SHALL last exactly one cycle, assert image_ready=1 (same cycle as last wr_en), then -> IDLE.
REQ-021 frame_reset=1 in CAPTURE SHALL abort: -> SYNC, count cleared, no image_ready; a pixel_valid in the same cycle is dropped (frame_reset wins).
REQ-022 frame_reset=1 in DONE SHALL still complete the image_ready pulse, then -> SYNC instead of IDLE.
REQ-023 wr_en SHALL be 0 in every cycle not following an accepted CAPTURE pixel.
REQ-024 Gaps in pixel_valid during CAPTURE SHALL hold count unchanged, no timeout.

Reset
REQ-025 reset=1 SHALL force IDLE, count=0, wr_en=0, wr_addr=0, wr_data=0, image_ready=0, busy=0 on the next edge.
REQ-026 reset SHALL override frame_reset and pixel_valid; reset mid-CAPTURE discards the partial frame without image_ready.

Configuration
REQ-027 Macro IMG_RECV_OVERRUN_EN SHALL add output overrun (1 bit) and IDLE-state pixel detection.
REQ-028 With IMG_RECV_OVERRUN_EN: pixel_valid=1 in IDLE or DONE sets overrun sticky 1; cleared by reset or entry to SYNC.
REQ-029 Without IMG_RECV_OVERRUN_EN: no overrun port, no related logic; IDLE pixels silently dropped.

Structure
REQ-030 Package image_pkg SHALL hold IMG_WIDTH/IMG_HEIGHT/PIX_W defaults, ADDR_W function and the rx_state_t enum.
REQ-031 Sub-module pixel_addr_counter SHALL own x/y/linear counters with clear, inc and last outputs.

Verification (sim params IMG_WIDTH=4, IMG_HEIGHT=2)
REQ-032 Pulse frame_reset 3 cycles, then 8 consecutive valid pixels 0x001..0x008 -> wr_addr 0..7 with matching data, image_ready single pulse with addr 7 write.
REQ-033 Same frame with valid gaps of 2 cycles between pixels -> identical writes, image_ready only after 8th pixel.
REQ-034 frame_reset after 5 pixels -> no image_ready; next frame restarts at wr_addr 0.
REQ-035 reset asserted after 3 pixels -> all outputs 0 next cycle, state IDLE; pixels before next frame_reset produce no wr_en.
REQ-036 pixel_valid with frame_reset same cycle in CAPTURE -> pixel dropped, wr_en stays 0.
REQ-037 With IMG_RECV_OVERRUN_EN: pixel_valid after completion -> overrun=1, cleared when frame_reset enters SYNC.

Source files
------------

// File: rtl/image_pkg.sv
`default_nettype none
// ============================================================================
// Module      : image_pkg
// Description : Shared definitions for the image frame receiver: default
//               geometry, address-width helper and receiver state type.
// Revision    : 1.0  initial release
// ============================================================================
package image_pkg;

    localparam int c_img_width_default  = 320;
    localparam int c_img_height_default = 240;
    localparam int c_pix_w_default      = 12;

    // Bits needed to address `depth` locations; never less than one bit so
    // degenerate geometries still produce a legal vector.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_addr_counter.sv
`default_nettype none
// ============================================================================
// Module      : pixel_addr_counter
// Description : Column / row / linear pixel counters for one frame.
//               clear has priority over inc. last is high while the counters
//               point at the final pixel of the frame; an increment there
//               wraps everything back to zero.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               clear           - force counters to zero
//               inc             - advance by one pixel
//               count           - linear address (y*IMG_WIDTH + x)
//               last            - current position is the final pixel
// Revision    : 1.0  initial release
// ============================================================================
module pixel_addr_counter
    import image_pkg::*;
#(
    parameter int IMG_WIDTH  = c_img_width_default,
    parameter int IMG_HEIGHT = c_img_height_default
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    clear,
    input  logic                                    inc,
    output logic [addr_w(IMG_WIDTH*IMG_HEIGHT)-1:0] count,
    output logic                                    last
);

    localparam int c_xw = addr_w(IMG_WIDTH);
    localparam int c_yw = addr_w(IMG_HEIGHT);
    localparam int c_aw = addr_w(IMG_WIDTH * IMG_HEIGHT);

    logic [c_xw-1:0] r_x;
    logic [c_yw-1:0] r_y;
    logic [c_aw-1:0] r_lin;
    logic            w_x_end;
    logic            w_y_end;

    assign w_x_end = (r_x == c_xw'(IMG_WIDTH - 1));
    assign w_y_end = (r_y == c_yw'(IMG_HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_x   <= '0;
            r_y   <= '0;
            r_lin <= '0;
        end else if (inc) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
            // Linear counter tracks y*IMG_WIDTH+x without a multiplier.
            r_lin <= (w_x_end && w_y_end) ? '0 : r_lin + 1'b1;
        end
    end

    assign count = r_lin;
    assign last  = w_x_end && w_y_end;

endmodule
`default_nettype wire

// File: rtl/image_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : image_frame_receiver
// Description : Receives a raster-ordered pixel stream and writes it into a
//               linear frame buffer. A frame_reset strobe arms the receiver,
//               pixels are captured until the frame is full, then a one-cycle
//               image_ready pulse accompanies the final write.
// Ports       : clk, reset                    - clock, sync active-high reset
//               frame_reset                   - sender frame-restart strobe
//               pixel_valid, pixel_in         - incoming pixel stream
//               wr_en, wr_addr, wr_data       - frame buffer write port
//               image_ready                   - frame complete pulse
//               busy                          - high in SYNC or CAPTURE
//               overrun                       - (IMG_RECV_OVERRUN_EN only)
//                                               sticky pixel-while-idle flag
// Config      : define IMG_RECV_OVERRUN_EN to add the overrun output.
// Revision    : 1.0  initial release
// ============================================================================
module image_frame_receiver
    import image_pkg::*;
#(
    parameter int IMG_WIDTH  = c_img_width_default,
    parameter int IMG_HEIGHT = c_img_height_default,
    parameter int PIX_W      = c_pix_w_default
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    frame_reset,
    input  logic                                    pixel_valid,
    input  logic [PIX_W-1:0]                        pixel_in,
    output logic                                    wr_en,
    output logic [addr_w(IMG_WIDTH*IMG_HEIGHT)-1:0] wr_addr,
    output logic [PIX_W-1:0]                        wr_data,
    output logic                                    image_ready,
    output logic                                    busy
`ifdef IMG_RECV_OVERRUN_EN
    ,
    output logic                                    overrun
`endif
);

    localparam int c_aw = addr_w(IMG_WIDTH * IMG_HEIGHT);

    rx_state_t        r_state;
    logic             r_wr_en;
    logic [c_aw-1:0]  r_wr_addr;
    logic [PIX_W-1:0] r_wr_data;
    logic             r_image_ready;
    logic [c_aw-1:0]  w_count;
    logic             w_last;
    logic             w_accept;
    logic             w_clear;

    // frame_reset wins over a simultaneous pixel in CAPTURE.
    assign w_accept = (r_state == CAPTURE) && pixel_valid && !frame_reset;
    // Counter sits at zero everywhere outside CAPTURE and on an abort.
    assign w_clear  = (r_state != CAPTURE) || frame_reset;

    pixel_addr_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_addr_counter (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .inc   (w_accept),
        .count (w_count),
        .last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_image_ready <= 1'b0;
        end else begin
            r_wr_en       <= 1'b0;
            r_image_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (frame_reset) r_state <= SYNC;
                end
                SYNC: begin
                    if (!frame_reset) r_state <= CAPTURE;
                end
                CAPTURE: begin
                    if (frame_reset) begin
                        r_state <= SYNC;
                    end else if (pixel_valid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_count;
                        r_wr_data <= pixel_in;
                        if (w_last) begin
                            r_state       <= DONE;
                            r_image_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= frame_reset ? SYNC : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign image_ready = r_image_ready;
    assign busy        = (r_state == SYNC) || (r_state == CAPTURE);

`ifdef IMG_RECV_OVERRUN_EN
    logic r_overrun;
    logic w_enter_sync;

    assign w_enter_sync = frame_reset && (r_state != SYNC);

    // Entering SYNC starts a fresh frame, so it clears the flag even if a
    // stray pixel arrives on the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_enter_sync) begin
            r_overrun <= 1'b0;
        end else if (pixel_valid && ((r_state == IDLE) || (r_state == DONE))) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`endif

endmodule
`default_nettype wire
